// File: rtl/rr_mux_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter_if
//   Bundles the N producer streams and the single consumer stream of the
//   round-robin mux arbiter.
//   Signals:
//     in_valid  [N]    per-channel valid       (producer -> arbiter)
//     in_data   [N*W]  packed channel data     (producer -> arbiter)
//     in_ready  [N]    per-channel ready       (arbiter -> producer)
//     out_valid        output word present     (arbiter -> consumer)
//     out_data  [W]    output word             (arbiter -> consumer)
//     out_chan  [CW]   source channel of word  (arbiter -> consumer)
//     out_ready        consumer accepts word   (consumer -> arbiter)
//   Modports: slave = the arbiter itself, master = producers/consumer side.
// ---------------------------------------------------------------------------
interface rr_mux_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_chan;
    logic           out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_chan
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_chan
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//   N-channel, W-bit registered multiplexer whose select comes from an
//   internal round-robin arbiter. Merges N valid/ready producer streams into
//   one valid/ready consumer stream with a single output register stage.
//   INVERT=1 drives the bitwise complement of the selected word.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous reset, active-high
//     bus  rr_mux_arbiter_if.slave (in_valid/in_data/in_ready,
//          out_valid/out_data/out_chan/out_ready)
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter int N      = 4,
    parameter int W      = 8,
    parameter int INVERT = 0
) (
    input  logic             clk,
    input  logic             rst,
    rr_mux_arbiter_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] ptr_r;
    logic          out_valid_r;
    logic [W-1:0]  out_data_r;
    logic [CW-1:0] out_chan_r;

    logic          load_en_s;
    logic          found_s;
    logic          xfer_s;
    logic [CW-1:0] grant_s;
    logic [CW-1:0] next_ptr_s;
    logic [N-1:0]  in_ready_s;
    logic [W-1:0]  sel_data_s;
    logic [W-1:0]  load_data_s;
    int            cand;

    // Round-robin search: first valid channel starting at ptr, wrapping mod N.
    always_comb begin
        found_s = 1'b0;
        grant_s = '0;
        cand    = 0;
        for (int off = 0; off < N; off++) begin
            cand = int'(ptr_r) + off;
            if (cand >= N) begin
                cand = cand - N;
            end else begin
                cand = cand;
            end
            if (!found_s && bus.in_valid[cand]) begin
                found_s = 1'b1;
                grant_s = CW'(cand);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant decode, data select, optional inversion and next pointer.
    always_comb begin
        // The register can take a word when empty or when its word leaves now.
        load_en_s  = !out_valid_r || bus.out_ready;
        xfer_s     = load_en_s && found_s && !rst;
        in_ready_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(grant_s) == i) begin
                sel_data_s    = bus.in_data[i*W +: W];
                in_ready_s[i] = xfer_s;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
        if (INVERT != 0) begin
            load_data_s = ~sel_data_s;
        end else begin
            load_data_s = sel_data_s;
        end
        if (int'(grant_s) == N - 1) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = CW'(int'(grant_s) + 1);
        end
    end

    // Output register stage and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_chan_r  <= '0;
            ptr_r       <= '0;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= load_data_s;
            out_chan_r  <= grant_s;
            ptr_r       <= next_ptr_s;
        end else if (load_en_s) begin
            // Nothing to load: an accepted word leaves, data/chan keep last value.
            out_valid_r <= 1'b0;
        end else begin
            // Stalled by the consumer: everything holds.
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_chan  = out_chan_r;
endmodule
